// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 8-bit processor front end.
//   - Address and instruction width constants
//   - HALT opcode value and the opcode bit flagging a two-byte instruction
//   - Fetch state encoding used by ifetch_unit
// Optional feature macro: IFETCH_HALT_EN (HALT opcode handling in ifetch_unit).
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int ADDR_W_C     = 8;
    localparam int INSTR_W_C    = 8;

    // Opcode that stops fetch when IFETCH_HALT_EN is defined
    localparam logic [7:0] HALT_OPCODE = 8'hFF;

    // Opcode bit that marks an instruction carrying an immediate byte
    localparam int IMM_FLAG_BIT = 7;

    typedef enum logic [1:0] {
        FETCH_OP  = 2'd0,
        FETCH_IMM = 2'd1,
        HALTED    = 2'd2
    } fetch_state_e;

endpackage : cpu_pkg

// File: rtl/ifetch_pc.sv
// -----------------------------------------------------------------------------
// ifetch_pc
// Program-counter register for the instruction fetch unit.
// Ports:
//   clk_i        rising-edge clock
//   reset_i      synchronous active-high reset, loads RESET_PC
//   load_i       redirect: PC <= load_addr_i (wins over increment)
//   load_addr_i  redirect target
//   inc_i        PC <= PC + 1, wrapping modulo 2^ADDR_W
//   pc_o         current PC (register output)
// -----------------------------------------------------------------------------
module ifetch_pc
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_C,
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // Next PC: redirect beats increment; natural wrap gives modulo arithmetic
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_addr_i;
        end else if (inc_i) begin
            pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end else begin
            pc_d = pc_q;
        end
    end

    // PC register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule : ifetch_pc

// File: rtl/ifetch_unit.sv
// -----------------------------------------------------------------------------
// ifetch_unit
// Instruction fetch unit: drives the address of a 256x8 asynchronous-read
// instruction memory, assembles one- or two-byte instructions and hands them
// to decode over a valid/ready handshake. Supports branch redirect and stall.
// Optional feature macro: IFETCH_HALT_EN -- opcode 8'hFF is delivered as a
// one-byte bundle and then fetch stops (halted=1) until reset or a branch.
// Without the macro, halted is tied low and 8'hFF is an ordinary two-byte op.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   Addr                   fetch address (PC register)
//   InstrCode              memory byte for Addr, same cycle
//   instr_valid/ready      decode handshake
//   instr_op/imm/len2/pc   registered instruction bundle
//   branch_taken/target    one-cycle redirect from execute
//   halted                 fetch stopped on HALT opcode
// -----------------------------------------------------------------------------
module ifetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_C,
    parameter int                INSTR_W  = INSTR_W_C,
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  Addr,
    input  logic [INSTR_W-1:0] InstrCode,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_op,
    output logic [INSTR_W-1:0] instr_imm,
    output logic               instr_len2,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               halted
);

    fetch_state_e       state_q;
    logic [INSTR_W-1:0] op_hold_q;   // opcode waiting for its immediate
    logic [ADDR_W-1:0]  op_pc_q;     // address of that opcode
    logic               valid_q;
    logic [INSTR_W-1:0] op_q;
    logic [INSTR_W-1:0] imm_q;
    logic               len2_q;
    logic [ADDR_W-1:0]  ipc_q;
`ifdef IFETCH_HALT_EN
    logic               halted_q;
`endif

    logic [ADDR_W-1:0]  pc_s;
    logic               slot_free_s;
    logic               handshake_s;
    logic               two_byte_s;
    logic               halt_op_s;
    logic               pc_inc_s;

    ifetch_pc #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk_i       (clk),
        .reset_i     (reset),
        .load_i      (branch_taken),
        .load_addr_i (branch_target),
        .inc_i       (pc_inc_s),
        .pc_o        (pc_s)
    );

    // Handshake status and opcode classification of the byte under Addr
    always_comb begin
        slot_free_s = !valid_q || instr_ready;
        handshake_s = valid_q && instr_ready;
`ifdef IFETCH_HALT_EN
        halt_op_s   = (InstrCode == HALT_OPCODE[INSTR_W-1:0]);
        two_byte_s  = InstrCode[IMM_FLAG_BIT] && !halt_op_s;
`else
        halt_op_s   = 1'b0;
        two_byte_s  = InstrCode[IMM_FLAG_BIT];
`endif
    end

    // PC advances on every byte consumed; never in a branch cycle or when halted
    always_comb begin
        pc_inc_s = 1'b0;
        case (state_q)
            FETCH_OP:  pc_inc_s = slot_free_s && !branch_taken;
            FETCH_IMM: pc_inc_s = slot_free_s && !branch_taken;
            default:   pc_inc_s = 1'b0;
        endcase
    end

    // Fetch FSM and registered bundle outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH_OP;
            op_hold_q <= {INSTR_W{1'b0}};
            op_pc_q   <= {ADDR_W{1'b0}};
            valid_q   <= 1'b0;
            op_q      <= {INSTR_W{1'b0}};
            imm_q     <= {INSTR_W{1'b0}};
            len2_q    <= 1'b0;
            ipc_q     <= {ADDR_W{1'b0}};
`ifdef IFETCH_HALT_EN
            halted_q  <= 1'b0;
`endif
        end else if (branch_taken) begin
            // Redirect drops the presented bundle and any half-fetched opcode
            state_q  <= FETCH_OP;
            valid_q  <= 1'b0;
`ifdef IFETCH_HALT_EN
            halted_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                FETCH_OP: begin
                    if (slot_free_s) begin
                        if (two_byte_s) begin
                            op_hold_q <= InstrCode;
                            op_pc_q   <= pc_s;
                            state_q   <= FETCH_IMM;
                            // Slot empties if the old bundle is taken now
                            if (handshake_s) begin
                                valid_q <= 1'b0;
                            end else begin
                                valid_q <= valid_q;
                            end
                        end else begin
                            op_q    <= InstrCode;
                            imm_q   <= {INSTR_W{1'b0}};
                            len2_q  <= 1'b0;
                            ipc_q   <= pc_s;
                            valid_q <= 1'b1;
`ifdef IFETCH_HALT_EN
                            if (halt_op_s) begin
                                state_q  <= HALTED;
                                halted_q <= 1'b1;
                            end else begin
                                state_q  <= FETCH_OP;
                            end
`else
                            state_q <= FETCH_OP;
`endif
                        end
                    end else begin
                        state_q <= FETCH_OP;
                    end
                end
                FETCH_IMM: begin
                    if (slot_free_s) begin
                        op_q    <= op_hold_q;
                        imm_q   <= InstrCode;
                        len2_q  <= 1'b1;
                        ipc_q   <= op_pc_q;
                        valid_q <= 1'b1;
                        state_q <= FETCH_OP;
                    end else begin
                        state_q <= FETCH_IMM;
                    end
                end
`ifdef IFETCH_HALT_EN
                HALTED: begin
                    // Only the HALT bundle itself can still be pending
                    if (handshake_s) begin
                        valid_q <= 1'b0;
                    end else begin
                        valid_q <= valid_q;
                    end
                end
`endif
                default: begin
                    state_q <= FETCH_OP;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign Addr        = pc_s;
    assign instr_valid = valid_q;
    assign instr_op    = op_q;
    assign instr_imm   = imm_q;
    assign instr_len2  = len2_q;
    assign instr_pc    = ipc_q;
`ifdef IFETCH_HALT_EN
    assign halted      = halted_q;
`else
    assign halted      = 1'b0;
`endif

endmodule : ifetch_unit

// File: tb/tb_ifetch_unit.sv
// -----------------------------------------------------------------------------
// tb_ifetch_unit
// Self-checking bench for ifetch_unit. The reference model walks the program
// image as an instruction stream: each accepted bundle must be the next
// instruction decoded from memory at the model's pointer; a branch restarts the
// stream at its target. Directed scenarios add explicit timing checks.
// -----------------------------------------------------------------------------
module tb_ifetch_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] Addr;
    logic [7:0] InstrCode;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr_op;
    logic [7:0] instr_imm;
    logic       instr_len2;
    logic [7:0] instr_pc;
    logic       branch_taken;
    logic [7:0] branch_target;
    logic       halted;

    logic [7:0] mem [0:255];

    int n_total = 0;
    int n_bad   = 0;

    // reference model state
    logic [7:0] m_ptr;
    logic       m_halted;
    logic [7:0] m_halt_addr;
    int         m_accepted;
    logic       st_pend;
    logic [7:0] st_op, st_imm, st_pc;
    logic       st_len2;

    always #5 clk = ~clk;

    assign InstrCode = mem[Addr];

    ifetch_unit #(
        .ADDR_W   (8),
        .INSTR_W  (8),
        .RESET_PC (8'h00)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .Addr          (Addr),
        .InstrCode     (InstrCode),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_op      (instr_op),
        .instr_imm     (instr_imm),
        .instr_len2    (instr_len2),
        .instr_pc      (instr_pc),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .halted        (halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Is the opcode a two-byte instruction under the build's rules?
    function automatic logic is_two(input logic [7:0] op);
`ifdef IFETCH_HALT_EN
        return op[7] && (op != 8'hFF);
`else
        return op[7];
`endif
    endfunction

    // Compare an accepted bundle with the next instruction of the stream
    task automatic model_accept();
        logic [7:0] eop, nx;
        logic       two;
        if (m_halted) begin
            chk("bundle_while_halted", {31'd0, instr_valid}, 32'd0);
        end else begin
            eop = mem[m_ptr];
            nx  = m_ptr + 8'd1;
            two = is_two(eop);
            chk("op",   {24'd0, instr_op},   {24'd0, eop});
            chk("pc",   {24'd0, instr_pc},   {24'd0, m_ptr});
            chk("len2", {31'd0, instr_len2}, {31'd0, two});
            chk("imm",  {24'd0, instr_imm},  two ? {24'd0, mem[nx]} : 32'd0);
            m_ptr = two ? (m_ptr + 8'd2) : nx;
            m_accepted++;
`ifdef IFETCH_HALT_EN
            if (eop == 8'hFF) begin
                chk("halt_flag", {31'd0, halted}, 32'd1);
                m_halted    = 1'b1;
                m_halt_addr = m_ptr;
            end
`endif
        end
    endtask

    // One clock: drive inputs, check against model, advance to next negedge
    task automatic step(input logic rdy, input logic br, input logic [7:0] tgt);
        instr_ready   = rdy;
        branch_taken  = br;
        branch_target = tgt;
        #1;
        if (st_pend) begin
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_op",    {24'd0, instr_op},    {24'd0, st_op});
            chk("stall_imm",   {24'd0, instr_imm},   {24'd0, st_imm});
            chk("stall_pc",    {24'd0, instr_pc},    {24'd0, st_pc});
            chk("stall_len2",  {31'd0, instr_len2},  {31'd0, st_len2});
        end
        st_pend = 1'b0;
`ifdef IFETCH_HALT_EN
        if (m_halted) begin
            chk("halted_hold", {31'd0, halted}, 32'd1);
            chk("halted_addr", {24'd0, Addr},   {24'd0, m_halt_addr});
        end
`else
        chk("halted_zero", {31'd0, halted}, 32'd0);
`endif
        if (instr_valid && instr_ready) model_accept();
        if (instr_valid && !instr_ready && !br) begin
            st_pend = 1'b1;
            st_op   = instr_op;
            st_imm  = instr_imm;
            st_pc   = instr_pc;
            st_len2 = instr_len2;
        end
        if (br) begin
            m_ptr    = tgt;
            m_halted = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        instr_ready   = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 8'h00;
        @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_addr",  {24'd0, Addr},        32'd0);
        chk("rst_op",    {24'd0, instr_op},    32'd0);
        chk("rst_imm",   {24'd0, instr_imm},   32'd0);
        chk("rst_pc",    {24'd0, instr_pc},    32'd0);
        chk("rst_len2",  {31'd0, instr_len2},  32'd0);
        chk("rst_halt",  {31'd0, halted},      32'd0);
        reset    = 1'b0;
        m_ptr    = 8'h00;
        m_halted = 1'b0;
        st_pend  = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    initial begin
        reset = 1'b1; instr_ready = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
        m_ptr = 8'h00; m_halted = 1'b0; m_halt_addr = 8'h00; m_accepted = 0;
        st_pend = 1'b0; st_op = 8'h00; st_imm = 8'h00; st_pc = 8'h00; st_len2 = 1'b0;
        clear_mem();
        @(negedge clk);

        // back-to-back one-byte instructions
        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 8'h00);
            chk("seq_valid", {31'd0, instr_valid}, 32'd1);
            chk("seq_op",    {24'd0, instr_op},    i + 1);
            chk("seq_pc",    {24'd0, instr_pc},    i);
            chk("seq_len2",  {31'd0, instr_len2},  32'd0);
        end

        // two-byte instruction
        clear_mem();
        mem[0] = 8'h85; mem[1] = 8'h3C; mem[2] = 8'h01;
        do_reset();
        step(1'b1, 1'b0, 8'h00);
        chk("imm_wait_valid", {31'd0, instr_valid}, 32'd0);
        step(1'b1, 1'b0, 8'h00);
        chk("two_valid", {31'd0, instr_valid}, 32'd1);
        chk("two_op",    {24'd0, instr_op},    32'h85);
        chk("two_imm",   {24'd0, instr_imm},   32'h3C);
        chk("two_len2",  {31'd0, instr_len2},  32'd1);
        chk("two_pc",    {24'd0, instr_pc},    32'h00);
        chk("two_next",  {24'd0, Addr},        32'h02);

        // stall holds Addr and bundle
        clear_mem();
        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03;
        do_reset();
        step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 8'h00);
            chk("stall_addr", {24'd0, Addr},     32'h01);
            chk("stall_op1",  {24'd0, instr_op}, 32'h01);
        end
        step(1'b1, 1'b0, 8'h00);
        chk("release_op", {24'd0, instr_op}, 32'h02);
        chk("release_pc", {24'd0, instr_pc}, 32'h01);

        // branch during FETCH_IMM discards the half-fetched opcode
        clear_mem();
        mem[0] = 8'h85; mem[1] = 8'h3C; mem[8'h40] = 8'h07;
        do_reset();
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'h40);
        chk("br_valid0", {31'd0, instr_valid}, 32'd0);
        chk("br_addr",   {24'd0, Addr},        32'h40);
        step(1'b1, 1'b0, 8'h00);
        chk("br_valid1", {31'd0, instr_valid}, 32'd1);
        chk("br_op",     {24'd0, instr_op},    32'h07);
        chk("br_pc",     {24'd0, instr_pc},    32'h40);

        // two-byte instruction straddling the address wrap
        clear_mem();
        mem[8'hFF] = 8'h9A; mem[0] = 8'h11;
        do_reset();
        step(1'b1, 1'b1, 8'hFF);
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        chk("wrap_pc",   {24'd0, instr_pc},   32'hFF);
        chk("wrap_op",   {24'd0, instr_op},   32'h9A);
        chk("wrap_imm",  {24'd0, instr_imm},  32'h11);
        chk("wrap_len2", {31'd0, instr_len2}, 32'd1);
        chk("wrap_addr", {24'd0, Addr},       32'h01);

`ifdef IFETCH_HALT_EN
        // HALT: bundle delivered, fetch freezes, branch resumes
        begin
            logic found;
            found = 1'b0;
            clear_mem();
            for (int i = 0; i < 5; i++) mem[i] = 8'h01;
            mem[5] = 8'hFF;
            do_reset();
            for (int i = 0; i < 12 && !found; i++) begin
                step(1'b1, 1'b0, 8'h00);
                if (instr_valid && instr_op == 8'hFF) found = 1'b1;
            end
            chk("halt_seen",  {31'd0, found},  32'd1);
            chk("halt_set",   {31'd0, halted}, 32'd1);
            chk("halt_pc",    {24'd0, instr_pc}, 32'h05);
            chk("halt_len2",  {31'd0, instr_len2}, 32'd0);
            chk("halt_addr",  {24'd0, Addr},   32'h06);
            for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00);
            chk("halt_valid0", {31'd0, instr_valid}, 32'd0);
            chk("halt_frozen", {24'd0, Addr},        32'h06);
            step(1'b1, 1'b1, 8'h00);
            chk("unhalt",      {31'd0, halted}, 32'd0);
            chk("unhalt_addr", {24'd0, Addr},   32'h00);
            step(1'b1, 1'b0, 8'h00);
            chk("resume_op", {24'd0, instr_op}, 32'h01);
            chk("resume_pc", {24'd0, instr_pc}, 32'h00);
        end
`else
        // without HALT support, 8'hFF is a two-byte opcode
        clear_mem();
        mem[0] = 8'hFF; mem[1] = 8'h22;
        do_reset();
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        chk("ff_op",   {24'd0, instr_op},   32'hFF);
        chk("ff_imm",  {24'd0, instr_imm},  32'h22);
        chk("ff_len2", {31'd0, instr_len2}, 32'd1);
`endif

        // randomized streams with random stalls and branches
        m_accepted = 0;
        for (int seg = 0; seg < 4; seg++) begin
            for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
            do_reset();
            for (int c = 0; c < 800; c++) begin
                logic rdy, br;
                rdy = (seg == 0) ? 1'b1 : ($urandom_range(0, 9) < 7);
                br  = ($urandom_range(0, 24) == 0);
                step(rdy, br, 8'($urandom));
            end
        end
        chk("rand_progress", {31'd0, (m_accepted > 400)}, 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_ifetch_unit

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch unit for the 8-bit processor; it is the initiator side of the instruction-memory read port. It drives the fetch address into the 256×8 asynchronous-read instruction memory and assembles one- or two-byte instructions. It presents them to decode over a valid/ready handshake and handles branch redirect, stall and halt. It sits between the instruction memory and the decode stage.

## Interface
- `ADDR_W`, 8, program-counter and memory-address width
- `INSTR_W`, 8, instruction byte width
- `RESET_PC`, 8'h00, first fetch address after reset
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high reset
- `Addr`  out  ADDR_W  fetch address to instruction memory (= PC register)
- `InstrCode`  in  INSTR_W  byte returned combinationally by memory for `Addr`
- `instr_valid`  out  1  instruction bundle is presented to decode
- `instr_ready`  in  1  decode accepts the bundle this cycle
- `instr_op`  out  INSTR_W  opcode byte
- `instr_imm`  out  INSTR_W  immediate byte (0 for one-byte instructions)
- `instr_len2`  out  1  bundle is a two-byte instruction
- `instr_pc`  out  ADDR_W  address of the opcode byte
- `branch_taken`  in  1  single-cycle redirect pulse from execute
- `branch_target`  in  ADDR_W  redirect address
- `halted`  out  1  fetch stopped on HALT opcode

## Operation
- Slot free when `!instr_valid || instr_ready`. A handshake completes on `instr_valid && instr_ready`.
- States:
  - FETCH_OP:
    - If the slot is free, capture `InstrCode` and increment PC.
    - If `InstrCode[7]`=1, store the opcode internally and go to FETCH_IMM.
    - Otherwise load the bundle (op, imm=0, len2=0, pc) and set valid.
    - If the slot is not free, hold PC and state.
  - FETCH_IMM:
    - If the slot is free, capture the immediate, increment PC, load the bundle (len2=1), set valid and go to FETCH_OP.
    - Otherwise hold.
  - HALTED:
    - No fetch; PC holds.
    - Valid clears after the HALT bundle is accepted.
    - Exit only via `reset` or `branch_taken`.
- Valid is set by a load and cleared by a handshake that has no simultaneous load.
- PC arithmetic is modulo 2^ADDR_W: 8'hFF+1 = 8'h00. A two-byte instruction at 8'hFF takes its immediate from 8'h00.
- `branch_taken` has the highest priority below `reset`:
  - PC ← `branch_target`; state ← FETCH_OP; `instr_valid` ← 0; any half-fetched opcode is discarded; `halted` ← 0.
  - A handshake in the same cycle still counts as completed.
  - No fetch is performed in the branch cycle.
- Reset mid-operation: every register returns to its reset value on the next edge, regardless of state or handshake.
- Reset values:
  - PC = `RESET_PC`; state FETCH_OP.
  - `instr_valid` = 0; `instr_op`, `instr_imm`, `instr_pc` = 0; `instr_len2` = 0; `halted` = 0.

## Timing
- `Addr` is the PC register output. Memory data is used in the same cycle: no wait state.
- One-byte instruction: bundle valid 1 cycle after the fetch edge. Sustained throughput is 1 instruction/cycle while `instr_ready`=1.
- Two-byte instruction: 2 cycles per instruction. Valid rises after the FETCH_IMM edge.
- After a branch: first bundle from the target is valid 2 cycles after the `branch_taken` edge for a one-byte target, 3 cycles for a two-byte target.
- First bundle after reset deassertion is valid 1 cycle after the first FETCH_OP edge.
- Outputs are registered; the bundle is stable while `instr_valid && !instr_ready`.

## Configuration
- `IFETCH_HALT_EN` defined:
  - Opcode 8'hFF is delivered as a normal one-byte bundle, then the unit enters HALTED and sets `halted`.
  - 8'hFF is never treated as two-byte.
- `IFETCH_HALT_EN` undefined:
  - No HALTED state; `halted` tied 0.
  - 8'hFF is an ordinary two-byte opcode, since bit 7 is set.

## Structure
- Shared package `cpu_pkg` holds:
  - `HALT_OPCODE` (8'hFF) and `IMM_FLAG_BIT` (7)
  - the fetch-state encoding (FETCH_OP, FETCH_IMM, HALTED)
  - address/instruction width constants
- One sub-module: `ifetch_pc`, the PC register with synchronous reset, load (branch) and increment enables. The state machine and bundle registers stay in `ifetch_unit`.

## Test plan
- Reset, memory 8'h01,8'h02,8'h03 at 0..2, `instr_ready`=1 → bundles op=01/pc=00, op=02/pc=01, op=03/pc=02 on consecutive cycles, all `instr_len2`=0.
- Memory 8'h85,8'h3C at 0..1 → one bundle op=85, imm=3C, len2=1, pc=00. Next fetch from 8'h02.
- Hold `instr_ready`=0 for 4 cycles with valid bundle op=01 → `Addr` and bundle unchanged. On release, next bundle op=02 follows 1 cycle later.
- `branch_taken`=1, target 8'h40, during FETCH_IMM of 8'h85 → no bundle for 8'h85. First bundle pc=40 appears 2 cycles after the pulse.
- Two-byte opcode at 8'hFF, byte 8'h11 at 8'h00 → bundle pc=FF, imm=11. Next fetch address 8'h01.
- With `IFETCH_HALT_EN`: 8'hFF at 8'h05 → bundle op=FF, then `halted`=1 and `Addr` frozen at 8'h06. `branch_taken` to 8'h00 clears `halted` and resumes fetch.
